// File: rtl/trivium_pkg.sv
// Shared constants and types for the Trivium keystream sequencer and its state datapath.
// Tap indices follow the 0-based Trivium numbering, where index i lives in state bit 287-i.
package trivium_pkg;

    localparam int KEY_W   = 80;
    localparam int IV_W    = 80;
    localparam int STATE_W = 288;

    // Where key, iv and the constant ones sit in the state register after a load
    localparam int KEY_MSB = 287;
    localparam int KEY_LSB = 208;
    localparam int IV_MSB  = 194;
    localparam int IV_LSB  = 115;

    localparam int T1_A     = 65;
    localparam int T1_B     = 92;
    localparam int T1_AND_A = 90;
    localparam int T1_AND_B = 91;
    localparam int T1_FB    = 170;

    localparam int T2_A     = 161;
    localparam int T2_B     = 176;
    localparam int T2_AND_A = 174;
    localparam int T2_AND_B = 175;
    localparam int T2_FB    = 263;

    localparam int T3_A     = 242;
    localparam int T3_B     = 287;
    localparam int T3_AND_A = 285;
    localparam int T3_AND_B = 286;
    localparam int T3_FB    = 68;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WARM = 2'd2,
        GEN  = 2'd3
    } ctrl_state_e;

    function automatic int sbit(input int idx);
        return STATE_W - 1 - idx;
    endfunction

endpackage

// File: rtl/trivium_core.sv
// 288-bit Trivium state register with load and single-step update.
// core_ks is the keystream bit that the next step will produce.
module trivium_core
    import trivium_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             core_load,
    input  logic             core_step,
    input  logic [KEY_W-1:0] key,
    input  logic [IV_W-1:0]  iv,
    output logic             core_ks
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    logic t1_lin;
    logic t2_lin;
    logic t3_lin;
    logic t1_fb;
    logic t2_fb;
    logic t3_fb;

    always_comb begin
        t1_lin = state_q[sbit(T1_A)] ^ state_q[sbit(T1_B)];
        t2_lin = state_q[sbit(T2_A)] ^ state_q[sbit(T2_B)];
        t3_lin = state_q[sbit(T3_A)] ^ state_q[sbit(T3_B)];
        t1_fb  = t1_lin ^ (state_q[sbit(T1_AND_A)] & state_q[sbit(T1_AND_B)])
                        ^ state_q[sbit(T1_FB)];
        t2_fb  = t2_lin ^ (state_q[sbit(T2_AND_A)] & state_q[sbit(T2_AND_B)])
                        ^ state_q[sbit(T2_FB)];
        t3_fb  = t3_lin ^ (state_q[sbit(T3_AND_A)] & state_q[sbit(T3_AND_B)])
                        ^ state_q[sbit(T3_FB)];
    end

    assign core_ks = t1_lin ^ t2_lin ^ t3_lin;

    // Three shift segments (93/84/111 bits), each fed by the previous segment's feedback
    always_comb begin
        state_d = state_q;
        if (core_load) begin
            state_d                  = '0;
            state_d[KEY_MSB:KEY_LSB] = key;
            state_d[IV_MSB:IV_LSB]   = iv;
            state_d[2:0]             = 3'b111;
        end else if (core_step) begin
            state_d = {t3_fb, state_q[287:196],
                       t1_fb, state_q[194:112],
                       t2_fb, state_q[110:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/trivium_ctrl.sv
// Trivium sequencer: key/iv load, warm-up count, keystream word packing and
// valid/ready output with backpressure that stalls the core instead of dropping bits.
module trivium_ctrl
    import trivium_pkg::*;
#(
    parameter int WARMUP_CYCLES = 1152,
    parameter int OUT_W         = 8,
    parameter int CNT_W         = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    input  logic [IV_W-1:0]  iv,
    output logic             busy,
    output logic             warm_done,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic [OUT_W-1:0] ks_data
);

    localparam int BIT_CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [BIT_CW-1:0] BIT_LAST  = BIT_CW'(OUT_W - 1);

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    logic [CNT_W-1:0]  warm_cnt_q;
    logic [CNT_W-1:0]  warm_cnt_d;
    logic [BIT_CW-1:0] bit_cnt_q;
    logic [BIT_CW-1:0] bit_cnt_d;
    logic [OUT_W-1:0]  collector_q;
    logic [OUT_W-1:0]  collector_d;
    logic [OUT_W-1:0]  ks_data_q;
    logic [OUT_W-1:0]  ks_data_d;
    logic              ks_valid_q;
    logic              ks_valid_d;
    logic [KEY_W-1:0]  key_q;
    logic [KEY_W-1:0]  key_d;
    logic [IV_W-1:0]   iv_q;
    logic [IV_W-1:0]   iv_d;

    logic              core_load;
    logic              core_step;
    logic              core_ks;
    logic              stall;
    logic [OUT_W-1:0]  full_word;

    trivium_core u_core (
        .clk       (clk),
        .rst       (rst),
        .core_load (core_load),
        .core_step (core_step),
        .key       (key_q),
        .iv        (iv_q),
        .core_ks   (core_ks)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start request wins over everything else and always restarts from LOAD
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                LOAD:    state_d = WARM;
                WARM:    if (warm_cnt_q == WARM_LAST) state_d = GEN;
                GEN:     state_d = GEN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Stall only when the last bit of a word is due but the previous word is still unaccepted
    always_comb begin
        busy      = 1'b0;
        warm_done = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        stall     = (bit_cnt_q == BIT_LAST) && ks_valid_q && !ks_ready;
        case (state_q)
            LOAD: begin
                busy      = 1'b1;
                core_load = 1'b1;
            end
            WARM: begin
                busy      = 1'b1;
                core_step = !start;
            end
            GEN: begin
                warm_done = 1'b1;
                core_step = !start && !stall;
            end
            default: ;
        endcase
    end

    always_comb begin
        full_word            = collector_q;
        full_word[OUT_W-1]   = core_ks;
    end

    always_comb begin
        warm_cnt_d  = warm_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        collector_d = collector_q;
        ks_data_d   = ks_data_q;
        ks_valid_d  = ks_valid_q;
        key_d       = key_q;
        iv_d        = iv_q;
        if (start) begin
            key_d       = key;
            iv_d        = iv;
            warm_cnt_d  = '0;
            bit_cnt_d   = '0;
            collector_d = '0;
            ks_valid_d  = 1'b0;
        end else begin
            case (state_q)
                LOAD: warm_cnt_d = '0;
                WARM: begin
                    if (warm_cnt_q == WARM_LAST) begin
                        warm_cnt_d = '0;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 1'b1;
                    end
                end
                GEN: begin
                    if (ks_valid_q && ks_ready) begin
                        ks_valid_d = 1'b0;
                    end
                    if (core_step) begin
                        collector_d[bit_cnt_q] = core_ks;
                        if (bit_cnt_q == BIT_LAST) begin
                            ks_data_d  = full_word;
                            ks_valid_d = 1'b1;
                            bit_cnt_d  = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            collector_q <= '0;
            ks_data_q   <= '0;
            ks_valid_q  <= 1'b0;
            key_q       <= '0;
            iv_q        <= '0;
        end else begin
            warm_cnt_q  <= warm_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            collector_q <= collector_d;
            ks_data_q   <= ks_data_d;
            ks_valid_q  <= ks_valid_d;
            key_q       <= key_d;
            iv_q        <= iv_d;
        end
    end

    assign ks_valid = ks_valid_q;
    assign ks_data  = ks_data_q;

endmodule

// File: tb/tb_trivium_ctrl.sv
// Directed bench for trivium_ctrl: latency, keystream words against a paper-numbered
// Trivium reference, backpressure hold, restart in WARM/GEN and reset priority.
module tb_trivium_ctrl;
    import trivium_pkg::*;

    localparam int OUT_W  = 8;
    localparam int WARM   = 1152;
    localparam int NWORDS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [79:0] key;
    logic [79:0] iv;
    logic        busy;
    logic        warm_done;
    logic        ks_valid;
    logic        ks_ready;
    logic [7:0]  ks_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_words [0:NWORDS-1];

    trivium_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .iv        (iv),
        .busy      (busy),
        .warm_done (warm_done),
        .ks_valid  (ks_valid),
        .ks_ready  (ks_ready),
        .ks_data   (ks_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference Trivium with s[1..288] numbered as in the original paper
    task automatic model_run(input logic [79:0] k, input logic [79:0] v);
        logic s [1:288];
        logic t1, t2, t3, z;
        int   g;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) s[i] = k[80-i];
        for (int i = 1; i <= 80; i++) s[93+i] = v[80-i];
        s[286] = 1'b1;
        s[287] = 1'b1;
        s[288] = 1'b1;
        for (int step = 0; step < WARM + NWORDS * OUT_W; step++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 288; i >= 179; i--) s[i] = s[i-1];
            s[178] = t2;
            for (int i = 177; i >= 95; i--) s[i] = s[i-1];
            s[94] = t1;
            for (int i = 93; i >= 2; i--) s[i] = s[i-1];
            s[1] = t3;
            if (step >= WARM) begin
                g = step - WARM;
                exp_words[g / OUT_W][g % OUT_W] = z;
            end
        end
    endtask

    // Presents start for exactly one edge (E0) and returns just after it
    task automatic apply_stimulus(input logic [79:0] k, input logic [79:0] v);
        start = 1'b1;
        key   = k;
        iv    = v;
        tick();
        start = 1'b0;
        key   = ~k;
        iv    = ~v;
    endtask

    // Called just after E0; returns just after E(WARM+OUT_W+1)
    task automatic check_latency(input string tag);
        check_output({tag, "_busy_load"}, busy, 1);
        repeat (WARM) tick();
        check_output({tag, "_busy_last"}, busy, 1);
        check_output({tag, "_wd_last"}, warm_done, 0);
        tick();
        check_output({tag, "_busy_gen"}, busy, 0);
        check_output({tag, "_wd_gen"}, warm_done, 1);
        repeat (OUT_W - 1) tick();
        check_output({tag, "_valid_early"}, ks_valid, 0);
        tick();
        check_output({tag, "_valid_first"}, ks_valid, 1);
    endtask

    task automatic collect_words(input int n, input bit random_ready, input string tag);
        int         got    = 0;
        int         budget = n * OUT_W * 4 + 100;
        logic       held   = 1'b0;
        logic [7:0] held_data = '0;
        while (got < n && budget > 0) begin
            if (held) begin
                check_output({tag, "_hold_valid"}, ks_valid, 1);
                check_output({tag, "_hold_data"}, ks_data, held_data);
            end
            ks_ready = random_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
            if (ks_valid && ks_ready) begin
                check_output($sformatf("%s_w%0d", tag, got), ks_data, exp_words[got]);
                got++;
            end
            held      = ks_valid && !ks_ready;
            held_data = ks_data;
            tick();
            budget--;
        end
        check_output({tag, "_count"}, got, n);
    endtask

    initial begin
        logic step_seen;
        logic [7:0] pend;
        int   wait_cnt;

        rst      = 1'b1;
        start    = 1'b0;
        key      = '0;
        iv       = '0;
        ks_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        $display("[TB] reset and idle");
        check_output("rst_busy", busy, 0);
        check_output("rst_wd", warm_done, 0);
        check_output("rst_valid", ks_valid, 0);
        check_output("rst_data", ks_data, 0);
        step_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_seen = step_seen | dut.core_step;
            tick();
        end
        check_output("idle_step", step_seen, 0);
        check_output("idle_busy", busy, 0);
        check_output("idle_valid", ks_valid, 0);

        $display("[TB] key=0 iv=0, ready tied high");
        model_run(80'h0, 80'h0);
        ks_ready = 1'b1;
        apply_stimulus(80'h0, 80'h0);
        check_latency("t2");
        collect_words(NWORDS, 1'b0, "t2");

        $display("[TB] key=0 iv=0, random backpressure");
        ks_ready = 1'b1;
        apply_stimulus(80'h0, 80'h0);
        check_latency("t3");
        collect_words(NWORDS, 1'b1, "t3");

        $display("[TB] restart during warm-up with key=1");
        apply_stimulus(80'h0, 80'h0);
        repeat (501) tick();
        check_output("t4_warm_busy", busy, 1);
        check_output("t4_warm_cnt", dut.warm_cnt_q, 500);
        model_run(80'h1, 80'h0);
        apply_stimulus(80'h1, 80'h0);
        check_output("t4_load", dut.state_q, LOAD);
        check_latency("t4");
        collect_words(32, 1'b0, "t4");

        $display("[TB] restart in GEN with a pending word");
        ks_ready = 1'b0;
        wait_cnt = 0;
        while (!ks_valid && wait_cnt < 40) begin
            tick();
            wait_cnt++;
        end
        check_output("t5_pending", ks_valid, 1);
        pend = ks_data;
        repeat (3) tick();
        check_output("t5_pend_hold", ks_data, pend);
        model_run(80'h0, 80'h0);
        apply_stimulus(80'h0, 80'h0);
        check_output("t5_drop", ks_valid, 0);
        ks_ready = 1'b1;
        check_latency("t5");
        collect_words(16, 1'b0, "t5");

        $display("[TB] reset with start at bit_cnt=3");
        wait_cnt = 0;
        while (dut.bit_cnt_q != 3'd3 && wait_cnt < 40) begin
            tick();
            wait_cnt++;
        end
        check_output("t6_bitcnt", dut.bit_cnt_q, 3);
        rst   = 1'b1;
        start = 1'b1;
        key   = 80'h1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_output("t6_busy", busy, 0);
        check_output("t6_wd", warm_done, 0);
        check_output("t6_valid", ks_valid, 0);
        check_output("t6_data", ks_data, 0);
        check_output("t6_state", dut.state_q, IDLE);
        repeat (5) tick();
        check_output("t6_idle_state", dut.state_q, IDLE);
        check_output("t6_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
